// File: rtl/tank_input_pkg.sv
// -----------------------------------------------------------------------------
// tank_input_pkg
// Shared types and constants for the per-player keyboard action decoder.
//   action_e        : keymap action index (UP, DOWN, LEFT, RIGHT, FIRE)
//   dir_e           : 8-way facing, 0 = N, increasing clockwise
//   NUM_ACTIONS     : number of bindable actions per player
//   HID_ROLLOVER    : HID "ErrorRollOver" usage code; it poisons a whole report
//   DEFAULT_KEYMAP  : keymap contents after reset, indexed [player][action]
//   dir_from_keys() : net-axis resolution of four direction keys into dir_e
// -----------------------------------------------------------------------------
package tank_input_pkg;

  typedef enum logic [2:0] {
    ACT_UP    = 3'd0,
    ACT_DOWN  = 3'd1,
    ACT_LEFT  = 3'd2,
    ACT_RIGHT = 3'd3,
    ACT_FIRE  = 3'd4
  } action_e;

  typedef enum logic [2:0] {
    DIR_N  = 3'd0,
    DIR_NE = 3'd1,
    DIR_E  = 3'd2,
    DIR_SE = 3'd3,
    DIR_S  = 3'd4,
    DIR_SW = 3'd5,
    DIR_W  = 3'd6,
    DIR_NW = 3'd7
  } dir_e;

  localparam int          NUM_ACTIONS  = 5;
  localparam logic [7:0]  HID_ROLLOVER = 8'h01;

  // P0: WASD + space, P1: arrow keys + enter, P2/P3 unbound.
  localparam logic [7:0] DEFAULT_KEYMAP [4][NUM_ACTIONS] = '{
    '{8'h1A, 8'h16, 8'h04, 8'h07, 8'h2C},
    '{8'h52, 8'h51, 8'h50, 8'h4F, 8'h28},
    '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
    '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00}
  };

  // Opposite keys cancel their axis. The result is only meaningful when at
  // least one net axis is active; the caller qualifies it.
  function automatic dir_e dir_from_keys(input logic up, input logic down,
                                         input logic left, input logic right);
    logic v;
    logic h;
    dir_e d;
    v = up ^ down;
    h = left ^ right;
    if (v && up) begin
      d = h ? (right ? DIR_NE : DIR_NW) : DIR_N;
    end else if (v) begin
      d = h ? (right ? DIR_SE : DIR_SW) : DIR_S;
    end else begin
      d = right ? DIR_E : DIR_W;
    end
    return d;
  endfunction

endpackage

// File: rtl/key_slot_match.sv
// -----------------------------------------------------------------------------
// key_slot_match
// Combinational check of one bound usage code against every keycode slot of
// a USB HID report. Code 0x00 means "unbound" and never matches.
// Ports:
//   code_i  [7:0]            usage code to look for
//   slots_i [NUM_SLOTS*8-1:0] packed report bytes, slot 0 in [7:0]
//   hit_o                    code is nonzero and present in some slot
// -----------------------------------------------------------------------------
module key_slot_match #(
  parameter int NUM_SLOTS = 8
) (
  input  logic [7:0]             code_i,
  input  logic [NUM_SLOTS*8-1:0] slots_i,
  output logic                   hit_o
);

  logic any_eq;

  always_comb begin
    any_eq = 1'b0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (slots_i[s*8 +: 8] == code_i) any_eq = 1'b1;
    end
    hit_o = any_eq && (code_i != 8'h00);
  end

endmodule

// File: rtl/key_action_decoder.sv
// -----------------------------------------------------------------------------
// key_action_decoder
// Once per frame, samples the USB keycode report, looks up each player's
// bound keys in a runtime-writable keymap and produces registered per-player
// movement and shot requests with a frame-counted fire cooldown.
//
// Ports:
//   clk, reset_n             100 MHz clock, asynchronous active-low reset
//   frame_tick               one-cycle pulse per frame; all decode happens here
//   enable                   game-running qualifier for move_valid/shoot_req
//   keycodes                 NUM_SLOTS packed report bytes, slot 0 in [7:0]
//   map_we/player/action/code  keymap write port, effective next cycle
//   move_valid[p]            a net movement axis is active
//   move_dir[3p+:3]          dir_e facing; held while no axis is active
//   shoot_req[p]             one-frame shot request
//   cooldown_busy[p]         fire cooldown counter is nonzero
//
// Handshake: there is no backpressure. Outputs are registered, change only on
// the clock after a frame_tick and are stable for the whole following frame.
//
// Build option: define AUTOFIRE_EN to let a held FIRE key re-fire every time
// the cooldown expires (period COOLDOWN_FRAMES+1 frames). Without it only a
// new press of FIRE can shoot.
// -----------------------------------------------------------------------------
module key_action_decoder
  import tank_input_pkg::*;
#(
  parameter int NUM_PLAYERS     = 2,
  parameter int NUM_SLOTS       = 8,
  parameter int COOLDOWN_FRAMES = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     frame_tick,
  input  logic                     enable,
  input  logic [NUM_SLOTS*8-1:0]   keycodes,
  input  logic                     map_we,
  input  logic [1:0]               map_player,
  input  logic [2:0]               map_action,
  input  logic [7:0]               map_code,
  output logic [NUM_PLAYERS-1:0]   move_valid,
  output logic [NUM_PLAYERS*3-1:0] move_dir,
  output logic [NUM_PLAYERS-1:0]   shoot_req,
  output logic [NUM_PLAYERS-1:0]   cooldown_busy
);

  localparam logic [7:0] CD_LOAD = 8'(COOLDOWN_FRAMES);

  logic [7:0] keymap_q [NUM_PLAYERS][NUM_ACTIONS];
  wire  [NUM_PLAYERS*NUM_ACTIONS-1:0] match_w;
  logic rollover;

  // Out-of-range player/action indices simply never select an entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        for (int a = 0; a < NUM_ACTIONS; a++) begin
          keymap_q[p][a] <= DEFAULT_KEYMAP[p][a];
        end
      end
    end else begin
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        for (int a = 0; a < NUM_ACTIONS; a++) begin
          if (map_we && (map_player == 2'(p)) && (map_action == 3'(a))) begin
            keymap_q[p][a] <= map_code;
          end
        end
      end
    end
  end

  // A rollover code anywhere means the keyboard could not report the real
  // key set, so the whole report is untrustworthy.
  always_comb begin
    rollover = 1'b0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (keycodes[s*8 +: 8] == HID_ROLLOVER) rollover = 1'b1;
    end
  end

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
    for (genvar a = 0; a < NUM_ACTIONS; a++) begin : g_action
      key_slot_match #(
        .NUM_SLOTS (NUM_SLOTS)
      ) u_match (
        .code_i  (keymap_q[p][a]),
        .slots_i (keycodes),
        .hit_o   (match_w[p*NUM_ACTIONS + a])
      );
    end

    logic [NUM_ACTIONS-1:0] held_q, held_d;
    logic [7:0]             cd_q, cd_d;
    logic                   mv_q, mv_d;
    logic [2:0]             dir_q, dir_d;
    logic                   shoot_q, shoot_d;
    logic                   axis_v, axis_h, fire_req;

    always_comb begin
      held_d   = held_q;
      cd_d     = cd_q;
      mv_d     = mv_q;
      dir_d    = dir_q;
      shoot_d  = shoot_q;
      axis_v   = 1'b0;
      axis_h   = 1'b0;
      fire_req = 1'b0;
      if (frame_tick) begin
        // held_q doubles as the previous-frame FIRE flag; on a discarded
        // report it is unchanged, so no fire edge can appear that frame.
        if (!rollover) held_d = match_w[p*NUM_ACTIONS +: NUM_ACTIONS];
        axis_v = held_d[ACT_UP] ^ held_d[ACT_DOWN];
        axis_h = held_d[ACT_LEFT] ^ held_d[ACT_RIGHT];
`ifdef AUTOFIRE_EN
        fire_req = held_d[ACT_FIRE];
`else
        fire_req = held_d[ACT_FIRE] & ~held_q[ACT_FIRE];
`endif
        shoot_d = fire_req && (cd_q == 8'd0) && enable;
        mv_d    = enable && (axis_v || axis_h);
        if (enable && (axis_v || axis_h)) begin
          dir_d = dir_from_keys(held_d[ACT_UP], held_d[ACT_DOWN],
                                held_d[ACT_LEFT], held_d[ACT_RIGHT]);
        end
        if (shoot_d) begin
          cd_d = CD_LOAD;
        end else if (cd_q != 8'd0) begin
          cd_d = cd_q - 8'd1;
        end
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        held_q  <= '0;
        cd_q    <= 8'd0;
        mv_q    <= 1'b0;
        dir_q   <= 3'd0;
        shoot_q <= 1'b0;
      end else begin
        held_q  <= held_d;
        cd_q    <= cd_d;
        mv_q    <= mv_d;
        dir_q   <= dir_d;
        shoot_q <= shoot_d;
      end
    end

    assign move_valid[p]     = mv_q;
    assign move_dir[p*3 +: 3] = dir_q;
    assign shoot_req[p]      = shoot_q;
    assign cooldown_busy[p]  = (cd_q != 8'd0);
  end

endmodule

// File: tb/tb_key_action_decoder.sv
module tb_key_action_decoder;

  localparam int NP = 2;
  localparam int NS = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic            frame_tick = 1'b0;
  logic            enable = 1'b1;
  logic [NS*8-1:0] keycodes = '0;
  logic            map_we = 1'b0;
  logic [1:0]      map_player = 2'd0;
  logic [2:0]      map_action = 3'd0;
  logic [7:0]      map_code = 8'd0;
  logic [NP-1:0]   move_valid;
  logic [NP*3-1:0] move_dir;
  logic [NP-1:0]   shoot_req;
  logic [NP-1:0]   cooldown_busy;

  key_action_decoder #(
    .NUM_PLAYERS     (2),
    .NUM_SLOTS       (8),
    .COOLDOWN_FRAMES (8)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .frame_tick    (frame_tick),
    .enable        (enable),
    .keycodes      (keycodes),
    .map_we        (map_we),
    .map_player    (map_player),
    .map_action    (map_action),
    .map_code      (map_code),
    .move_valid    (move_valid),
    .move_dir      (move_dir),
    .shoot_req     (shoot_req),
    .cooldown_busy (cooldown_busy)
  );

  // ---------------- scoreboard ----------------
  // Expected word: {move_valid[1:0], dir1, dir0, shoot_req[1:0], busy[1:0]}
  localparam int W = 12;
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] keys;
    logic        en;
    logic [1:0]  mv;
    logic [2:0]  d0;
    logic [2:0]  d1;
    logic [1:0]  sh;
    logic [1:0]  bz;
  } vec_t;
  vec_t vecs[$];

  function automatic logic [W-1:0] pk(input logic [1:0] mv, input logic [2:0] d1,
                                      input logic [2:0] d0, input logic [1:0] sh,
                                      input logic [1:0] bz);
    return {mv, d1, d0, sh, bz};
  endfunction

  function automatic logic [W-1:0] dut_word();
    return {move_valid, move_dir, shoot_req, cooldown_busy};
  endfunction

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got mv=%b dir=%h/%h sh=%b bz=%b, want mv=%b dir=%h/%h sh=%b bz=%b",
               name, got[11:10], got[9:7], got[6:4], got[3:2], got[1:0],
               exp[11:10], exp[9:7], exp[6:4], exp[3:2], exp[1:0]);
    end
  endtask

  task automatic add(input logic [63:0] keys, input logic en, input logic [1:0] mv,
                     input logic [2:0] d0, input logic [2:0] d1,
                     input logic [1:0] sh, input logic [1:0] bz);
    vec_t v;
    v.keys = keys; v.en = en; v.mv = mv; v.d0 = d0; v.d1 = d1; v.sh = sh; v.bz = bz;
    vecs.push_back(v);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input string name, input logic [63:0] keys, input logic en,
                      input logic [W-1:0] exp);
    logic [W-1:0] e;
    @(negedge clk);
    keycodes   = keys;
    enable     = en;
    frame_tick = 1'b1;
    exp_q.push_back(exp);
    @(negedge clk);
    frame_tick = 1'b0;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = exp_q.pop_front();
      check(name, dut_word(), e);
    end
  endtask

  task automatic map_write(input logic [1:0] pl, input logic [2:0] act, input logic [7:0] code);
    @(negedge clk);
    map_we = 1'b1; map_player = pl; map_action = act; map_code = code;
    @(negedge clk);
    map_we = 1'b0;
  endtask

  // ---------------- test ----------------
  initial begin
    // Vector table: one row per frame, expected outputs after that frame.
    add(64'h071A,     1, 2'b01, 3'd1, 3'd0, 2'b00, 2'b00); // D+W -> P0 NE
    add(64'h160704,   1, 2'b01, 3'd4, 3'd0, 2'b00, 2'b00); // A+D cancel, S
    add(64'h0,        1, 2'b00, 3'd4, 3'd0, 2'b00, 2'b00); // release keeps facing
    add(64'h2C,       1, 2'b00, 3'd4, 3'd0, 2'b01, 2'b01); // fire edge
    for (int i = 0; i < 7; i++) add(64'h2C, 1, 2'b00, 3'd4, 3'd0, 2'b00, 2'b01);
    for (int i = 0; i < 4; i++) add(64'h2C, 1, 2'b00, 3'd4, 3'd0, 2'b00, 2'b00);
    add(64'h0,        1, 2'b00, 3'd4, 3'd0, 2'b00, 2'b00); // release one frame
    add(64'h2C,       1, 2'b00, 3'd4, 3'd0, 2'b01, 2'b01); // re-press fires
    add(64'h4F52,     1, 2'b10, 3'd4, 3'd1, 2'b00, 2'b01); // P1 Up+Right -> NE
    add(64'h01000000, 1, 2'b10, 3'd4, 3'd1, 2'b00, 2'b01); // rollover: P1 unchanged
    add(64'h0,        1, 2'b00, 3'd4, 3'd1, 2'b00, 2'b01);
    for (int i = 0; i < 4; i++) add(64'h0, 1, 2'b00, 3'd4, 3'd1, 2'b00, 2'b01);
    add(64'h0,        1, 2'b00, 3'd4, 3'd1, 2'b00, 2'b00); // cooldown expired
    add(64'h282C,     1, 2'b00, 3'd4, 3'd1, 2'b11, 2'b11); // simultaneous shots
    add(64'h071A282C, 0, 2'b00, 3'd4, 3'd1, 2'b00, 2'b11); // disabled: no move, dir held
    add(64'h282C,     1, 2'b00, 3'd4, 3'd1, 2'b00, 2'b11); // held across enable rise
    for (int i = 0; i < 5; i++) add(64'h0, 1, 2'b00, 3'd4, 3'd1, 2'b00, 2'b11);
    add(64'h0,        1, 2'b00, 3'd4, 3'd1, 2'b00, 2'b00);

    // Reset, and check the reset state.
    repeat (3) @(negedge clk);
    check("reset_state", dut_word(), '0);
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      tick($sformatf("vec%0d", i), vecs[i].keys, vecs[i].en,
           pk(vecs[i].mv, vecs[i].d1, vecs[i].d0, vecs[i].sh, vecs[i].bz));
    end

    // Remap P0 FIRE to Q; out-of-range writes must not alias onto P1.
    map_write(2'd0, 3'd4, 8'h14);
    map_write(2'd3, 3'd0, 8'h2C);
    map_write(2'd1, 3'd5, 8'h2C);
    map_write(2'd1, 3'd7, 8'h2C);
    tick("remap_old_fire", 64'h2C, 1, pk(2'b00, 3'd1, 3'd4, 2'b00, 2'b00));
    tick("remap_new_fire", 64'h14, 1, pk(2'b00, 3'd1, 3'd4, 2'b01, 2'b01));
    tick("remap_hold",     64'h14, 1, pk(2'b00, 3'd1, 3'd4, 2'b00, 2'b01));

    // Asynchronous reset mid-cooldown, with frame ticks while held in reset.
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check("async_reset", dut_word(), '0);
    @(negedge clk);
    keycodes = 64'h071A; frame_tick = 1'b1;
    repeat (2) @(negedge clk);
    frame_tick = 1'b0;
    check("tick_in_reset", dut_word(), '0);
    reset_n = 1'b1;
    @(negedge clk);
    check("after_release", dut_word(), '0);
    // Keymap back to defaults: Q no longer fires, space does.
    tick("default_map_q",     64'h14, 1, pk(2'b00, 3'd0, 3'd0, 2'b00, 2'b00));
    tick("default_map_space", 64'h2C, 1, pk(2'b00, 3'd0, 3'd0, 2'b01, 2'b01));

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_action_decoder.md
Name: key_action_decoder

Overview:
- Parametrised successor to the per-module keycode decoding currently duplicated inside the tank, tank_2, bullet and bullet_2 modules.
- Snapshots the MicroBlaze USB keycode GPIO words once per frame and maps them, through a runtime-programmable keymap, to per-player 8-way direction, move-valid and shoot-request outputs.
- Edge-detects fire and enforces a frame-counted cooldown.
- Sits between mb_usb and the tank/bullet instances; scales to NUM_PLAYERS tanks.

Parameters:
- NUM_PLAYERS, 2, number of independent players/tanks (1..4).
- NUM_SLOTS, 8, keycode bytes per report (4 = keycode0 only, 8 = keycode0+keycode1).
- COOLDOWN_FRAMES, 8, frames after a shot before fire is accepted again (1..255).

Ports:
- clk  in  1  system clock (100 MHz domain).
- reset_n  in  1  asynchronous, active-low reset.
- frame_tick  in  1  one-clk pulse per frame (vsync rising edge, synchronised by the caller).
- enable  in  1  game-running qualifier from game_state_machine.
- keycodes  in  NUM_SLOTS*8  packed keycode bytes; slot 0 in bits [7:0].
- map_we  in  1  keymap write strobe.
- map_player  in  2  player index for the write.
- map_action  in  3  action index for the write (0=UP, 1=DOWN, 2=LEFT, 3=RIGHT, 4=FIRE).
- map_code  in  8  USB HID usage code to bind.
- move_valid  out  NUM_PLAYERS  per player: at least one net axis is active.
- move_dir  out  NUM_PLAYERS*3  per player: 0=N, 1=NE, 2=E, 3=SE, 4=S, 5=SW, 6=W, 7=NW.
- shoot_req  out  NUM_PLAYERS  per player: shot request, held for exactly one frame.
- cooldown_busy  out  NUM_PLAYERS  per player: cooldown counter nonzero.

Behaviour:
- Reset (async, reset_n=0):
  - all outputs 0, cooldown counters 0, previous-fire flags 0.
  - keymap loads defaults:
    - P0: W=0x1A, S=0x16, A=0x04, D=0x07, FIRE=0x2C.
    - P1: Up=0x52, Down=0x51, Left=0x50, Right=0x4F, FIRE=0x28.
    - P2, P3: all 0x00.
- Keymap writes:
  - Take effect in the cycle after map_we.
  - Writes with map_player>=NUM_PLAYERS or map_action>4 are ignored.
  - Code 0x00 never matches, so an action bound to 0x00 is disabled.
- Decode on a frame_tick cycle:
  - held[p][a] = any slot equals keymap[p][a] and that code is nonzero.
  - Rollover error: if any slot equals 0x01, the report is discarded. held keeps its previous value and counters still decrement.
  - Outputs are registered and update the cycle after frame_tick (latency 1 clk). They hold until the next update.
- Direction:
  - Net vertical = UP xor DOWN; net horizontal = LEFT xor RIGHT. Opposite keys both held cancel that axis.
  - move_dir is taken from the net axes.
  - If neither axis is active: move_valid=0 and move_dir keeps its last value, so the tank keeps its facing.
- Shoot:
  - fire_edge = held FIRE and not held FIRE on the previous frame.
  - shoot_req[p]=1 when fire_edge, cooldown==0 and enable; the counter then loads COOLDOWN_FRAMES.
  - Otherwise shoot_req[p]=0.
- Cooldown counter:
  - Decrements by 1 per frame_tick when nonzero and saturates at 0.
  - A load has priority over a decrement in the same tick.
- enable=0:
  - At the next tick, move_valid and shoot_req go to 0; move_dir is held.
  - Counters keep decrementing; the previous-fire flag still tracks, so a key held across enable rising does not fire.
- frame_tick while reset_n=0 is ignored.
- Reset mid-cooldown clears the counter.
- Players are fully independent; simultaneous shots from different players are all honoured.

Optional Feature:
- AUTOFIRE_EN
  - Defined: holding FIRE re-fires. A level-held FIRE with cooldown==0 and enable produces shoot_req, so the repeat period is COOLDOWN_FRAMES+1 frames.
  - Undefined: only fire edges shoot, as specified above.

Decomposition:
- Package tank_input_pkg holds:
  - action_e enum (UP, DOWN, LEFT, RIGHT, FIRE).
  - dir_e 3-bit enum.
  - NUM_ACTIONS=5 and HID_ROLLOVER=8'h01.
  - default keymap constant array [4][5] of 8-bit codes.
- One sub-module, key_slot_match: a combinational compare of one 8-bit code against NUM_SLOTS slots, instanced NUM_PLAYERS*5 times.
- Per-player state (previous fire, cooldown, output registers) lives in a generate loop.

Test Plan:
- Direction diagonal, default map:
  - keycodes=0x0000_0000_0000_071A (D+W), one tick → P0 move_valid=1, move_dir=1 (NE).
  - P1 move_valid=0, move_dir=0.
- Opposite-key cancel:
  - 0x04,0x07,0x16 held (A, D, S), tick → P0 move_dir=4 (S).
  - Then release all, tick → move_valid=0, move_dir stays 4.
- Fire edge and cooldown:
  - Hold 0x2C for 12 ticks → shoot_req=1 only in frame 1, cooldown_busy=1 for frames 1..8.
  - Release 1 frame, press again → shoot_req=1.
  - With AUTOFIRE_EN: shots in frames 1, 10.
- Rollover:
  - P1 holding 0x52; next report has slot 3=0x01 → P1 outputs unchanged that frame.
- Remap:
  - Write P0 FIRE=0x14 (Q), then press 0x2C → no shot; press 0x14 → shoot_req[0]=1.
  - Write with map_player=3 when NUM_PLAYERS=2 → no change.
- Enable/reset:
  - enable=0 while FIRE held → shoot_req=0.
  - enable→1 while still held → no shot.
  - Assert reset_n=0 mid-cooldown → all outputs 0 immediately, cooldown_busy=0.
